// File: rtl/flush_pkg.sv
// Shared types and constants for the pipeline flush/stall controller.
// Optional build macro: FLUSH_PERF_CNT_EN (per-source redirect and bubble counters).
package flush_pkg;

    localparam int unsigned STG_PC = 0;
    localparam int unsigned STG_D  = 1;
    localparam int unsigned STG_E  = 2;
    localparam int unsigned STG_M  = 3;
    localparam int unsigned STG_W  = 4;

    localparam int unsigned SRC_JAL  = 0;
    localparam int unsigned SRC_BR   = 1;
    localparam int unsigned SRC_TRAP = 2;

    localparam int unsigned STG_IDX_W  = 3;
    localparam int unsigned MAX_STAGES = 8;
    localparam int unsigned REC_CNT_W  = 4;
    localparam int unsigned PERF_W     = 32;

    typedef enum logic [1:0] {RUN, FROZEN, RECOVER} flush_state_t;

    // Bits 0..k set.
    function automatic logic [MAX_STAGES-1:0] upto_mask(input logic [STG_IDX_W-1:0] k);
        upto_mask = MAX_STAGES'((9'd2 << k) - 9'd1);
    endfunction

    // Single bit k+1 set; vanishes when k is the last stage.
    function automatic logic [MAX_STAGES-1:0] next_bit(input logic [STG_IDX_W-1:0] k);
        next_bit = MAX_STAGES'(9'd2 << k);
    endfunction

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Request/response bundle between the pipeline datapath and the flush controller.
// Optional build macro: FLUSH_PERF_CNT_EN adds the performance counter outputs.
interface pipe_flush_ctrl_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned NUM_REDIR  = 3
);
    localparam int unsigned SEL_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    logic [NUM_REDIR-1:0]  redir_valid;
    logic [NUM_STAGES-1:0] stall_req;
    logic                  freeze;
    logic [NUM_STAGES-1:0] flush;
    logic [NUM_STAGES-1:0] stall;
    logic                  redir_fire;
    logic [SEL_W-1:0]      redir_sel;
    logic                  busy;
`ifdef FLUSH_PERF_CNT_EN
    logic [NUM_REDIR-1:0][31:0] perf_redir_cnt;
    logic [31:0]                perf_bubble_cnt;

    modport master (output redir_valid, stall_req, freeze,
                    input  flush, stall, redir_fire, redir_sel, busy,
                           perf_redir_cnt, perf_bubble_cnt);
    modport slave  (input  redir_valid, stall_req, freeze,
                    output flush, stall, redir_fire, redir_sel, busy,
                           perf_redir_cnt, perf_bubble_cnt);
`else
    modport master (output redir_valid, stall_req, freeze,
                    input  flush, stall, redir_fire, redir_sel, busy);
    modport slave  (input  redir_valid, stall_req, freeze,
                    output flush, stall, redir_fire, redir_sel, busy);
`endif
endinterface

// File: rtl/redir_arbiter.sv
// Age-priority redirect select: oldest stage wins, lower index breaks ties.
module redir_arbiter
    import flush_pkg::*;
#(
    parameter int unsigned NUM_REDIR = 3,
    parameter int unsigned SEL_W     = 2,
    parameter logic [STG_IDX_W*NUM_REDIR-1:0] REDIR_STAGE = {3'd3, 3'd2, 3'd1}
) (
    input  logic [NUM_REDIR-1:0] valid,
    output logic                 any,
    output logic [SEL_W-1:0]     sel,
    output logic [STG_IDX_W-1:0] stg
);

    // Strictly-greater compare keeps the first (lowest index) source on a tie.
    always_comb begin
        any = 1'b0;
        sel = '0;
        stg = '0;
        for (int i = 0; i < int'(NUM_REDIR); i++) begin
            if (valid[i] && (!any || (REDIR_STAGE[STG_IDX_W*i +: STG_IDX_W] > stg))) begin
                any = 1'b1;
                sel = SEL_W'(i);
                stg = REDIR_STAGE[STG_IDX_W*i +: STG_IDX_W];
            end
        end
    end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Pipeline hazard/redirect controller: per-register flush and stall vectors,
// age-ordered redirect arbitration, freeze replay and post-redirect bubbles.
// Optional build macro: FLUSH_PERF_CNT_EN (saturating perf counters).
module pipe_flush_ctrl
    import flush_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 5,
    parameter int unsigned NUM_REDIR      = 3,
    parameter logic [STG_IDX_W*NUM_REDIR-1:0] REDIR_STAGE = {3'd3, 3'd2, 3'd1},
    parameter int unsigned RECOVER_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_flush_ctrl_if.slave bus
);

    localparam int unsigned NS    = NUM_STAGES;
    localparam int unsigned NR    = NUM_REDIR;
    localparam int unsigned SEL_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    flush_state_t           state_q, state_d;
    logic                   pend_v_q, pend_v_d;
    logic [SEL_W-1:0]       pend_sel_q, pend_sel_d;
    logic [STG_IDX_W-1:0]   pend_stg_q, pend_stg_d;
    logic [REC_CNT_W-1:0]   rec_cnt_q, rec_cnt_d;

    logic                   live_any, win_any;
    logic [SEL_W-1:0]       live_sel, win_sel;
    logic [STG_IDX_W-1:0]   live_stg, win_stg;
    logic [NR-1:0]          rec_ok, pend_oh, arb_vld, stg_bad;

    logic                   hz_any, redir_go;
    logic [STG_IDX_W-1:0]   hz_s;

    logic [NS-1:0]          flush_c, stall_c;
    logic                   fire_c, busy_c;
    logic [SEL_W-1:0]       sel_c;

    // Per-source static properties: usable during recovery, legal stage index.
    for (genvar i = 0; i < int'(NR); i++) begin : g_src
        assign rec_ok[i]  = (REDIR_STAGE[STG_IDX_W*i +: STG_IDX_W] >= STG_IDX_W'(STG_E));
        assign stg_bad[i] = (REDIR_STAGE[STG_IDX_W*i +: STG_IDX_W] == '0) ||
                            (32'(REDIR_STAGE[STG_IDX_W*i +: STG_IDX_W]) >= 32'(NS));
    end

    assign pend_oh = pend_v_q ? (NR'(1) << pend_sel_q) : '0;

    // Live requests only; feeds the capture path while frozen.
    redir_arbiter #(.NUM_REDIR(NR), .SEL_W(SEL_W), .REDIR_STAGE(REDIR_STAGE)) u_arb_live (
        .valid (bus.redir_valid),
        .any   (live_any),
        .sel   (live_sel),
        .stg   (live_stg)
    );

    // Candidate set depends on state: merge pending on release, mask D-stage in recovery.
    always_comb begin
        arb_vld = bus.redir_valid;
        case (state_q)
            FROZEN:  arb_vld = bus.redir_valid | pend_oh;
            RECOVER: arb_vld = bus.redir_valid & rec_ok;
            default: arb_vld = bus.redir_valid;
        endcase
    end

    redir_arbiter #(.NUM_REDIR(NR), .SEL_W(SEL_W), .REDIR_STAGE(REDIR_STAGE)) u_arb_win (
        .valid (arb_vld),
        .any   (win_any),
        .sel   (win_sel),
        .stg   (win_stg)
    );

    // Oldest stalling stage.
    always_comb begin
        hz_any = 1'b0;
        hz_s   = '0;
        for (int i = 0; i < int'(NS); i++) begin
            if (bus.stall_req[i]) begin
                hz_any = 1'b1;
                hz_s   = STG_IDX_W'(i);
            end
        end
    end

    // A redirect younger than the stalled instruction is held back so flush and
    // stall never collide; the level-held request fires once the stall clears.
    assign redir_go = win_any && (!hz_any || (win_stg >= hz_s));

    // Output vectors and next-state decode.
    always_comb begin
        flush_c    = '0;
        stall_c    = '0;
        fire_c     = 1'b0;
        sel_c      = '0;
        busy_c     = (state_q != RUN);
        state_d    = state_q;
        pend_v_d   = pend_v_q;
        pend_sel_d = pend_sel_q;
        pend_stg_d = pend_stg_q;
        rec_cnt_d  = rec_cnt_q;

        if (!rst_n) begin
            flush_c = '1;
            busy_c  = 1'b0;
        end else if (bus.freeze) begin
            stall_c = '1;
            state_d = FROZEN;
            if (live_any && (!pend_v_q || (live_stg >= pend_stg_q))) begin
                pend_v_d   = 1'b1;
                pend_sel_d = live_sel;
                pend_stg_d = live_stg;
            end
        end else begin
            pend_v_d = 1'b0;
            if (state_q == RECOVER) begin
                stall_c = NS'(MAX_STAGES'(1));
                flush_c = NS'(MAX_STAGES'(2));
            end

            if (redir_go) begin
                fire_c  = 1'b1;
                sel_c   = win_sel;
                stall_c = '0;
                flush_c = flush_c | NS'(upto_mask(win_stg) & ~MAX_STAGES'(1));
                state_d   = (RECOVER_CYCLES > 0) ? RECOVER : RUN;
                rec_cnt_d = REC_CNT_W'(RECOVER_CYCLES);
            end else begin
                if (hz_any) begin
                    stall_c = stall_c | NS'(upto_mask(hz_s));
                    flush_c = NS'(next_bit(hz_s));
                end
                case (state_q)
                    RECOVER: begin
                        rec_cnt_d = (rec_cnt_q != '0) ? REC_CNT_W'(rec_cnt_q - 1'b1) : '0;
                        state_d   = (rec_cnt_q <= REC_CNT_W'(1)) ? RUN : RECOVER;
                    end
                    FROZEN:  state_d = (rec_cnt_q != '0) ? RECOVER : RUN;
                    default: state_d = RUN;
                endcase
            end
        end
    end

    // State, pending redirect and recovery counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pend_v_q   <= 1'b0;
            pend_sel_q <= '0;
            pend_stg_q <= '0;
            rec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pend_v_q   <= pend_v_d;
            pend_sel_q <= pend_sel_d;
            pend_stg_q <= pend_stg_d;
            rec_cnt_q  <= rec_cnt_d;
        end
    end

    assign bus.flush      = flush_c;
    assign bus.stall      = stall_c;
    assign bus.redir_fire = fire_c;
    assign bus.redir_sel  = sel_c;
    assign bus.busy       = busy_c;

`ifdef FLUSH_PERF_CNT_EN
    logic [NR-1:0][PERF_W-1:0] perf_redir_q;
    logic [PERF_W-1:0]         perf_bub_q;

    // Saturating per-source redirect and bubble counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_redir_q <= '0;
            perf_bub_q   <= '0;
        end else begin
            for (int i = 0; i < int'(NR); i++) begin
                if (fire_c && (sel_c == SEL_W'(i)) && (perf_redir_q[i] != '1))
                    perf_redir_q[i] <= perf_redir_q[i] + 1'b1;
            end
            if ((|flush_c[NS-1:1]) && (perf_bub_q != '1))
                perf_bub_q <= perf_bub_q + 1'b1;
        end
    end

    assign bus.perf_redir_cnt  = perf_redir_q;
    assign bus.perf_bubble_cnt = perf_bub_q;
`endif

    // Configuration and flush/stall exclusivity checks.
    a_cfg: assert property (@(posedge clk) stg_bad == '0)
        else $error("pipe_flush_ctrl: REDIR_STAGE entry out of range");
    a_excl: assert property (@(posedge clk) (flush_c & stall_c) == '0)
        else $error("pipe_flush_ctrl: flush and stall both set");

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Scoreboard bench for pipe_flush_ctrl: dut_a uses no recovery bubbles, dut_b two.
module tb_pipe_flush_ctrl;

    typedef struct {
        logic [4:0] flush;
        logic [4:0] stall;
        logic       fire;
        logic [1:0] sel;
        logic       busy;
        string      name;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;
    int   checks;
    int   errors;
    exp_t qa[$];
    exp_t qb[$];

    pipe_flush_ctrl_if #(.NUM_STAGES(5), .NUM_REDIR(3)) bus_a ();
    pipe_flush_ctrl_if #(.NUM_STAGES(5), .NUM_REDIR(3)) bus_b ();

    pipe_flush_ctrl #(.NUM_STAGES(5), .NUM_REDIR(3), .RECOVER_CYCLES(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a)
    );

    pipe_flush_ctrl #(.NUM_STAGES(5), .NUM_REDIR(3), .RECOVER_CYCLES(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input exp_t e, input logic [4:0] f, input logic [4:0] s,
                           input logic fi, input logic [1:0] se, input logic b);
        checks++;
        if (f !== e.flush || s !== e.stall || fi !== e.fire || b !== e.busy ||
            (e.fire && se !== e.sel)) begin
            errors++;
            $display("FAIL %s: got flush=%b stall=%b fire=%b sel=%0d busy=%b, want flush=%b stall=%b fire=%b sel=%0d busy=%b",
                     e.name, f, s, fi, se, b, e.flush, e.stall, e.fire, e.sel, e.busy);
        end
    endtask

    // Monitors: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (qa.size() != 0) begin
            exp_t e;
            e = qa.pop_front();
            compare(e, bus_a.flush, bus_a.stall, bus_a.redir_fire, bus_a.redir_sel, bus_a.busy);
        end
    end

    always @(negedge clk) begin
        if (qb.size() != 0) begin
            exp_t e;
            e = qb.pop_front();
            compare(e, bus_b.flush, bus_b.stall, bus_b.redir_fire, bus_b.redir_sel, bus_b.busy);
        end
    end

    // Drive one cycle of stimulus on a DUT and queue its expected response.
    task automatic step(input int which, input logic r, input logic [2:0] rv,
                        input logic [4:0] sr, input logic fz,
                        input logic [4:0] ef, input logic [4:0] es, input logic efi,
                        input logic [1:0] esel, input logic eb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.flush = ef; e.stall = es; e.fire = efi; e.sel = esel; e.busy = eb; e.name = nm;
        if (which == 0) begin
            rst_a = r; bus_a.redir_valid = rv; bus_a.stall_req = sr; bus_a.freeze = fz;
            qa.push_back(e);
        end else begin
            rst_b = r; bus_b.redir_valid = rv; bus_b.stall_req = sr; bus_b.freeze = fz;
            qb.push_back(e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.redir_valid = '0; bus_a.stall_req = '0; bus_a.freeze = 1'b0;
        bus_b.redir_valid = '0; bus_b.stall_req = '0; bus_b.freeze = 1'b0;

        // dut_a: no recovery bubbles
        step(0, 0, 3'b000, 5'b00000, 0, 5'b11111, 5'b00000, 0, 0, 0, "a_rst0");
        step(0, 0, 3'b000, 5'b00000, 0, 5'b11111, 5'b00000, 0, 0, 0, "a_rst1");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "a_idle");
        step(0, 1, 3'b010, 5'b00000, 0, 5'b00110, 5'b00000, 1, 1, 0, "a_br_e");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "a_after_br");
        step(0, 1, 3'b000, 5'b00010, 0, 5'b00100, 5'b00011, 0, 0, 0, "a_lduse");
        step(0, 1, 3'b010, 5'b00010, 0, 5'b00110, 5'b00000, 1, 1, 0, "a_br_vs_lduse");
        step(0, 1, 3'b001, 5'b00000, 0, 5'b00010, 5'b00000, 1, 0, 0, "a_jal");
        step(0, 1, 3'b111, 5'b00000, 0, 5'b01110, 5'b00000, 1, 2, 0, "a_all_src");
        step(0, 1, 3'b011, 5'b00000, 0, 5'b00110, 5'b00000, 1, 1, 0, "a_jal_br");
        step(0, 1, 3'b000, 5'b10000, 0, 5'b00000, 5'b11111, 0, 0, 0, "a_stall_w");
        step(0, 1, 3'b000, 5'b00001, 0, 5'b00010, 5'b00001, 0, 0, 0, "a_stall_pc");
        step(0, 1, 3'b100, 5'b00100, 0, 5'b01110, 5'b00000, 1, 2, 0, "a_trap_vs_stall");
        step(0, 1, 3'b010, 5'b00100, 0, 5'b00110, 5'b00000, 1, 1, 0, "a_br_eq_stall");
        // freeze, capture, replay
        step(0, 1, 3'b010, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 0, "a_frz0");
        step(0, 1, 3'b100, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 1, "a_frz1");
        step(0, 1, 3'b000, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 1, "a_frz2");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b01110, 5'b00000, 1, 2, 1, "a_frz_rel");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "a_post_rel");
        step(0, 1, 3'b100, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 0, "a_keep0");
        step(0, 1, 3'b010, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 1, "a_keep1");
        step(0, 1, 3'b001, 5'b00000, 0, 5'b01110, 5'b00000, 1, 2, 1, "a_rel_merge");
        step(0, 1, 3'b000, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 0, "a_frz_empty");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1, "a_rel_empty");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "a_idle2");
        // reset while frozen with a pending redirect
        step(0, 1, 3'b010, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 0, "a_frz_rst0");
        step(0, 1, 3'b000, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 1, "a_frz_rst1");
        step(0, 0, 3'b000, 5'b00000, 1, 5'b11111, 5'b00000, 0, 0, 0, "a_rst_frz");
        step(0, 0, 3'b000, 5'b00000, 0, 5'b11111, 5'b00000, 0, 0, 0, "a_rst_low");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "a_after_rst");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "a_after_rst2");

`ifdef FLUSH_PERF_CNT_EN
        step(0, 0, 3'b000, 5'b00000, 0, 5'b11111, 5'b00000, 0, 0, 0, "a_perf_rst");
        for (int k = 0; k < 5; k++)
            step(0, 1, 3'b010, 5'b00000, 0, 5'b00110, 5'b00000, 1, 1, 0, "a_perf_br");
        step(0, 1, 3'b100, 5'b00000, 0, 5'b01110, 5'b00000, 1, 2, 0, "a_perf_trap");
        step(0, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "a_perf_idle");
        checks++;
        if (bus_a.perf_redir_cnt[1] !== 32'd5) begin
            errors++;
            $display("FAIL perf_br: got %0d, want 5", bus_a.perf_redir_cnt[1]);
        end
        checks++;
        if (bus_a.perf_redir_cnt[2] !== 32'd1) begin
            errors++;
            $display("FAIL perf_trap: got %0d, want 1", bus_a.perf_redir_cnt[2]);
        end
        checks++;
        if (bus_a.perf_redir_cnt[0] !== 32'd0) begin
            errors++;
            $display("FAIL perf_jal: got %0d, want 0", bus_a.perf_redir_cnt[0]);
        end
        checks++;
        if (bus_a.perf_bubble_cnt !== 32'd6) begin
            errors++;
            $display("FAIL perf_bubble: got %0d, want 6", bus_a.perf_bubble_cnt);
        end
`endif

        // dut_b: two recovery bubbles per redirect
        step(1, 0, 3'b000, 5'b00000, 0, 5'b11111, 5'b00000, 0, 0, 0, "b_rst0");
        step(1, 0, 3'b000, 5'b00000, 0, 5'b11111, 5'b00000, 0, 0, 0, "b_rst1");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "b_idle");
        step(1, 1, 3'b010, 5'b00000, 0, 5'b00110, 5'b00000, 1, 1, 0, "b_br");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00010, 5'b00001, 0, 0, 1, "b_rec1");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00010, 5'b00001, 0, 0, 1, "b_rec2");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "b_run");
        step(1, 1, 3'b010, 5'b00000, 0, 5'b00110, 5'b00000, 1, 1, 0, "b_br2");
        step(1, 1, 3'b100, 5'b00000, 0, 5'b01110, 5'b00000, 1, 2, 1, "b_trap_rec");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00010, 5'b00001, 0, 0, 1, "b_rec3");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00010, 5'b00001, 0, 0, 1, "b_rec4");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "b_run2");
        step(1, 1, 3'b010, 5'b00000, 0, 5'b00110, 5'b00000, 1, 1, 0, "b_br3");
        step(1, 1, 3'b001, 5'b00000, 0, 5'b00010, 5'b00001, 0, 0, 1, "b_jal_ign");
        step(1, 1, 3'b000, 5'b00010, 0, 5'b00100, 5'b00011, 0, 0, 1, "b_rec_stall");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "b_run3");
        step(1, 1, 3'b010, 5'b00000, 0, 5'b00110, 5'b00000, 1, 1, 0, "b_br4");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00010, 5'b00001, 0, 0, 1, "b_rec5");
        step(1, 1, 3'b000, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0, 1, "b_frz");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1, "b_frz_rel");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00010, 5'b00001, 0, 0, 1, "b_rec_resume");
        step(1, 1, 3'b000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, "b_run4");

        // Let the monitors drain, bounded.
        for (int k = 0; k < 10 && (qa.size() != 0 || qb.size() != 0); k++)
            @(negedge clk);
        @(posedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d entries left, want 0", qa.size(), qb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
